// File: rtl/alu_pkg.sv
// Shared types and the combinational ALU kernel for the pipelined integer unit.
// The kernel works at a fixed maximum width; the caller passes its real width.
package alu_pkg;

  localparam int ALU_OP_W  = 3;
  localparam int ALU_MAX_W = 64;
  localparam int ALU_IDX_W = $clog2(ALU_MAX_W);

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic [ALU_MAX_W-1:0] result;
    logic                 ovf;
  } alu_res_t;

  // Operands must arrive zero-extended from 'width' bits; results are masked back to 'width'.
  function automatic alu_res_t alu_compute(input alu_op_e              op,
                                           input logic [ALU_MAX_W-1:0] a,
                                           input logic [ALU_MAX_W-1:0] b,
                                           input int unsigned          width);
    logic [ALU_MAX_W-1:0] mask;
    logic [ALU_MAX_W-1:0] sum;
    logic [ALU_MAX_W-1:0] diff;
    logic [ALU_IDX_W-1:0] msb;
    logic                 sa;
    logic                 sb;
    alu_res_t             r;
    mask = (width >= ALU_MAX_W) ? '1 : ((ALU_MAX_W'(1) << width) - ALU_MAX_W'(1));
    msb  = ALU_IDX_W'(width - 1);
    sum  = (a + b) & mask;
    diff = (a - b) & mask;
    sa   = a[msb];
    sb   = b[msb];
    r    = '0;
    case (op)
      ALU_ADD: begin
        r.result = sum;
        r.ovf    = (sa == sb) && (sum[msb] != sa);
      end
      ALU_SUB: begin
        r.result = diff;
        r.ovf    = (sa != sb) && (diff[msb] != sa);
      end
      ALU_AND: r.result = a & b;
      ALU_OR:  r.result = a | b;
      ALU_XOR: r.result = a ^ b;
      ALU_SLT: r.result = ALU_MAX_W'((sa != sb) ? sa : (a < b));
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One pipeline slot {valid, result, tag, ovf}; clear kills only the valid bit,
// reset zeroes everything so the outputs read 0 after reset.
module alu_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] res_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             ovf_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] res_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             ovf_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    tag_d = tag_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      vld_d = 1'b0;
    end else if (en_i) begin
      vld_d = vld_i;
      res_d = res_i;
      tag_d = tag_i;
      ovf_d = ovf_i;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
      tag_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      tag_q <= tag_d;
      ovf_q <= ovf_d;
    end
  end

  assign vld_o = vld_q;
  assign res_o = res_q;
  assign tag_o = tag_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_alu_unit.sv
// Fully pipelined integer ALU: compute at entry, then LATENCY-deep shift chain
// with a single global stall, flush, and tag pass-through to the CDB.
module pipe_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int TAG_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_ovf,
  output logic                busy
);

  logic [LATENCY-1:0]            vld_q;
  logic [LATENCY-1:0][WIDTH-1:0] res_q;
  logic [LATENCY-1:0][TAG_W-1:0] tag_q;
  logic [LATENCY-1:0]            ovf_q;

  logic     stall;
  logic     advance;
  logic     accept;
  alu_res_t alu_p0;
  logic [WIDTH-1:0] res_p0;
  logic     ovf_p0;

  // Stall is a plain global enable: bubbles are held, never squeezed out.
  assign stall    = vld_q[LATENCY-1] && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // Stage 0 boundary: result computed from the issue bus as it is accepted.
  always_comb begin
    alu_p0 = alu_compute(alu_op_e'(in_op), ALU_MAX_W'(in_a), ALU_MAX_W'(in_b), WIDTH);
    res_p0 = WIDTH'(alu_p0.result);
    ovf_p0 = alu_p0.ovf;
  end

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic             vld_in;
    logic [WIDTH-1:0] res_in;
    logic [TAG_W-1:0] tag_in;
    logic             ovf_in;

    if (i == 0) begin : g_head
      assign vld_in = accept;
      assign res_in = res_p0;
      assign tag_in = in_tag;
      assign ovf_in = ovf_p0;
    end else begin : g_tail
      assign vld_in = vld_q[i-1];
      assign res_in = res_q[i-1];
      assign tag_in = tag_q[i-1];
      assign ovf_in = ovf_q[i-1];
    end

    alu_pipe_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en_i  (advance),
      .clr_i (flush),
      .vld_i (vld_in),
      .res_i (res_in),
      .tag_i (tag_in),
      .ovf_i (ovf_in),
      .vld_o (vld_q[i]),
      .res_o (res_q[i]),
      .tag_o (tag_q[i]),
      .ovf_o (ovf_q[i])
    );
  end

  // Output boundary: last stage drives the CDB.
  assign out_valid  = vld_q[LATENCY-1];
  assign out_result = res_q[LATENCY-1];
  assign out_tag    = tag_q[LATENCY-1];
  assign out_ovf    = ovf_q[LATENCY-1];
  assign busy       = |vld_q;

endmodule
